// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
// Conditions 16 raw asynchronous pad inputs for the AHB GPIO peripheral's GPIOIN bus.
// Each bit passes through a two-flop synchroniser and then a per-bit debounce filter.
// The filtered word is registered and presented with a parity bit in bit 16.
// The block also flags data changes and reports whether any debounce is pending.
module gpio_in_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [15:0] PADIN,
    input  logic        PARITYSEL,
    output logic [16:0] GPIODATA,
    output logic        CHANGED,
    output logic        STABLE
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;
    logic [15:0]   r_deb;
    logic [CW-1:0] r_cnt [16];
    logic [15:0]   r_data;
    logic          r_changed;
    logic          w_cnt_idle;

    // Two-flop synchroniser. There is no logic between the stages, which leaves
    // the full cycle for metastability to resolve.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: sequential state uses non-blocking assignments, so r_sync2 takes the
        // old r_sync1. A blocking assignment here would collapse the two stages into one.
        if (!HRESETn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= PADIN;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce. The filtered bit flips only after the synchronised bit has
    // differed from it for DEBOUNCE_CYCLES consecutive edges. Any return to the
    // filtered value discards the partial count.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_deb <= '0;
            // NOTE: the counter array is a small set of flops, not a RAM. Every entry
            // is reset explicitly so that a reset mid-count throws away all partial counts.
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Output register. CHANGED pulses in the cycle new filtered data first appears
    // on GPIODATA[15:0].
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_data    <= r_deb;
            r_changed <= (r_deb != r_data);
        end
    end

    // Checks whether every debounce counter is idle. This feeds STABLE.
    always_comb begin
        // NOTE: the default comes first so that every path assigns w_cnt_idle.
        // Without it, always_comb would infer a latch.
        w_cnt_idle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (r_cnt[i] != '0) begin
                w_cnt_idle = 1'b0;
            end
        end
    end

    // The parity bit makes the XOR of {GPIODATA, PARITYSEL} equal to 1.
    // Because it is combinational, a PARITYSEL change shows up on bit 16 in the same cycle.
    assign GPIODATA = {~(^r_data ^ PARITYSEL), r_data};
    assign CHANGED  = r_changed;
    assign STABLE   = (r_sync2 == r_deb) && w_cnt_idle;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner
// Checks gpio_in_conditioner against a behavioural model.
// The model is a two-edge pad delay, per-bit run lengths and a parity computed from a ones count.
// The run starts with the directed scenarios and then applies randomized pad activity.
module tb_gpio_in_conditioner;

    localparam int D = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] PADIN;
    logic        PARITYSEL;
    logic [16:0] GPIODATA;
    logic        CHANGED;
    logic        STABLE;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [15:0] m_pad_d1;   // pad as seen one edge ago
    logic [15:0] m_pad_d2;   // pad as seen two edges ago
    logic [15:0] m_deb;
    int          m_run [16]; // consecutive edges the delayed pad has disagreed with m_deb
    logic [15:0] m_data;
    logic        m_changed;

    gpio_in_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PADIN     (PADIN),
        .PARITYSEL (PARITYSEL),
        .GPIODATA  (GPIODATA),
        .CHANGED   (CHANGED),
        .STABLE    (STABLE)
    );

    // Free-running clock with a 10-unit period.
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pad_d1  = '0;
        m_pad_d2  = '0;
        m_deb     = '0;
        m_data    = '0;
        m_changed = 1'b0;
        for (int i = 0; i < 16; i++) m_run[i] = 0;
    endtask

    // Applies one clock edge to the model, using the values from before the edge.
    task automatic model_edge();
        m_changed = (m_deb != m_data);
        m_data    = m_deb;
        for (int i = 0; i < 16; i++) begin
            if (m_pad_d2[i] == m_deb[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == D) begin
                    m_deb[i] = m_pad_d2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_pad_d2 = m_pad_d1;
        m_pad_d1 = PADIN;
    endtask

    function automatic logic [16:0] exp_gpio();
        logic p;
        // Pick the parity bit so that the total number of ones in {data, p, PARITYSEL} is odd.
        p = ((($countones(m_data) + int'(PARITYSEL)) % 2) == 0);
        return {p, m_data};
    endfunction

    function automatic logic exp_stable();
        logic idle;
        idle = 1'b1;
        for (int i = 0; i < 16; i++) if (m_run[i] != 0) idle = 1'b0;
        return (m_pad_d2 == m_deb) && idle;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".gpiodata"}, 32'(GPIODATA), 32'(exp_gpio()));
        check({tag, ".changed"},  32'(CHANGED),  32'(m_changed));
        check({tag, ".stable"},   32'(STABLE),   32'(exp_stable()));
    endtask

    // Drives the inputs away from the edge, takes one edge, then checks 1 unit later.
    task automatic step(input logic [15:0] pad, input logic psel, input string tag);
        PADIN     = pad;
        PARITYSEL = psel;
        @(posedge HCLK);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
    endtask

    task automatic release_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        logic [15:0] pad;
        logic        psel;

        HRESETn   = 1'b0;
        PADIN     = '0;
        PARITYSEL = 1'b0;
        model_reset();

        // 1. Reset values, and the parity bit following PARITYSEL combinationally.
        #7;
        check("rst.gpiodata", 32'(GPIODATA), 32'h10000);
        check("rst.changed",  32'(CHANGED),  32'h0);
        check("rst.stable",   32'(STABLE),   32'h1);
        PARITYSEL = 1'b1;
        #1;
        check("rst.psel1", 32'(GPIODATA), 32'h00000);
        PARITYSEL = 1'b0;
        release_reset();

        // 2. Steady change to 16'h00A5, with exact edge timing.
        for (int k = 1; k <= 9; k++) begin
            step(16'h00A5, 1'b0, "steady");
            if (k == 1) check("steady.stable_e1", 32'(STABLE), 32'h1);
            if (k >= 2 && k <= 5) check("steady.stable_low", 32'(STABLE), 32'h0);
            if (k == 6) begin
                check("steady.data_e6", 32'(GPIODATA), 32'h10000);
                check("steady.stable_e6", 32'(STABLE), 32'h1);
            end
            if (k == 7) begin
                check("steady.data_e7", 32'(GPIODATA), 32'h100A5);
                check("steady.changed_e7", 32'(CHANGED), 32'h1);
            end
            if (k == 8) check("steady.changed_e8", 32'(CHANGED), 32'h0);
        end

        // 4. Parity mode switch with the data held at 16'h00A5.
        @(negedge HCLK);
        PARITYSEL = 1'b1;
        #1;
        check("psel.same_cycle", 32'(GPIODATA), 32'h000A5);
        step(16'h00A5, 1'b1, "psel");
        check("psel.changed", 32'(CHANGED), 32'h0);
        check("psel.data", 32'(GPIODATA[15:0]), 32'h00A5);

        // 3. Glitch rejection: a 3-cycle pulse on bit 0 is never propagated.
        do_reset();
        release_reset();
        for (int k = 1; k <= 12; k++) begin
            step((k <= 3) ? 16'h0001 : 16'h0000, 1'b0, "glitch");
            check("glitch.data", 32'(GPIODATA), 32'h10000);
            check("glitch.changed", 32'(CHANGED), 32'h0);
        end
        check("glitch.stable_end", 32'(STABLE), 32'h1);

        // 5. Staggered bits: bit 3 is raised, then bit 7 two cycles later.
        do_reset();
        release_reset();
        for (int k = 1; k <= 11; k++) begin
            step((k <= 2) ? 16'h0008 : 16'h0088, 1'b0, "stagger");
            if (k == 7) begin
                check("stagger.data_e7", 32'(GPIODATA[15:0]), 32'h0008);
                check("stagger.changed_e7", 32'(CHANGED), 32'h1);
            end
            if (k == 8) check("stagger.changed_e8", 32'(CHANGED), 32'h0);
            if (k == 9) begin
                check("stagger.data_e9", 32'(GPIODATA[15:0]), 32'h0088);
                check("stagger.changed_e9", 32'(CHANGED), 32'h1);
            end
            if (k == 10) check("stagger.changed_e10", 32'(CHANGED), 32'h0);
        end

        // 6. Reset mid-count: partial counts are lost, and the full latency restarts.
        do_reset();
        release_reset();
        for (int k = 1; k <= 5; k++) step(16'h00A5, 1'b0, "midrst_pre");
        @(negedge HCLK);
        do_reset();
        check("midrst.data_zero", 32'(GPIODATA[15:0]), 32'h0);
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            step(16'h00A5, 1'b0, "midrst_post");
            if (k == 6) check("midrst.data_e6", 32'(GPIODATA[15:0]), 32'h0000);
            if (k == 7) check("midrst.data_e7", 32'(GPIODATA[15:0]), 32'h00A5);
        end

        // Randomized pad activity: each bit toggles with probability 1/8 per cycle.
        // PARITYSEL changes occasionally, and a reset is applied now and then.
        pad  = 16'h00A5;
        psel = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            pad = pad ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) psel = ~psel;
            if ($urandom_range(0, 399) == 0) begin
                @(negedge HCLK);
                do_reset();
                release_reset();
            end
            step(pad, psel, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input-side conditioning stage that drives the 17-bit `GPIOIN` bus of the AHB GPIO peripheral. It takes 16 raw, asynchronous pad/switch inputs and passes them through a two-flop synchroniser and a per-bit debounce filter. It then presents the filtered word with a parity bit in bit 16, in the same parity convention the GPIO peripheral checks. It also flags data changes and reports input stability.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised bit must differ from its filtered value before the filtered value updates. Legal range 1..65535. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `HCLK`: input, 1 bit. Single clock; every flop is on its rising edge.
- `HRESETn`: input, 1 bit. Reset, asynchronous, active-low.
- `PADIN`: input, 16 bits. Raw pad inputs; asynchronous to `HCLK` and may bounce.
- `PARITYSEL`: input, 1 bit. Parity mode, shared with the GPIO peripheral. 0 = odd overall parity, 1 = even.
- `GPIODATA`: output, 17 bits.
  - [15:0]: registered filtered data.
  - [16]: parity bit.
  - Connects to the GPIO peripheral's `GPIOIN`.
- `CHANGED`: output, 1 bit. One-cycle pulse in the cycle new data first appears on `GPIODATA[15:0]`.
- `STABLE`: output, 1 bit. High when no bit has a debounce pending.

## Operation

**Synchroniser**
- Per bit: `sync1 <= PADIN`, then `sync2 <= sync1`.
- No logic between `sync1` and `sync2`.

**Debounce filter** (per bit i, fully independent of other bits). On each edge:
- If `sync2[i] == deb[i]`: `cnt[i] <= 0`. A bounce back to the filtered value discards the partial count.
- Else, if `cnt[i] == DEBOUNCE_CYCLES-1`: `deb[i] <= sync2[i]` and `cnt[i] <= 0`.
- Else: `cnt[i] <= cnt[i]+1`.
- With `DEBOUNCE_CYCLES`=1, `deb` follows `sync2` one edge later.

**Output register**
- `GPIODATA[15:0] <= deb` every cycle.
- `CHANGED <= (deb != GPIODATA[15:0])`.

**Parity**
- Combinational: `GPIODATA[16] = ~(^GPIODATA[15:0] ^ PARITYSEL)`.
- Result: XOR of {`GPIODATA`, `PARITYSEL`} is always 1, which the downstream checker accepts as parity-good.
- A change on `PARITYSEL` alone updates bit 16 in the same cycle and never asserts `CHANGED`.

**Stability**
- `STABLE = (sync2 == deb) && (all cnt == 0)`. Combinational from registers.

**Multiple bits**
- Several bits changing together each count independently.
- If all their counters expire on the same edge, a single `CHANGED` pulse is produced.
- Staggered expiry produces one pulse per distinct update edge.

## Timing

**Reset values** (asynchronous, immediate on `HRESETn` low):
- `sync1`, `sync2`, `deb`, all `cnt`, `GPIODATA[15:0]`: 0.
- `CHANGED`: 0.
- `GPIODATA[16]`: `~PARITYSEL`.
- `STABLE`: 1 while `PADIN`'s synchronised value is 0.

**Latency**
- Edge 1 is the first edge that samples a new, steady `PADIN` value.
- `deb` updates at edge `DEBOUNCE_CYCLES`+2.
- `GPIODATA[15:0]` and `CHANGED` update at edge `DEBOUNCE_CYCLES`+3 (edge 7 with the default).
- `CHANGED` deasserts at the following edge unless another update occurs.

**Pulse width**
- A pad pulse shorter than `DEBOUNCE_CYCLES` steady cycles at `sync2` is never propagated.

**Reset mid-count**
- All partial counts are lost.
- After release, a steady pad value reappears after the full latency, counted from the first post-reset edge.

**Handshake**
- None; `GPIODATA` is a continuously valid level.
- The consumer may sample it on any edge.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

1. **Reset:** hold `HRESETn`=0 with `PARITYSEL`=0 → `GPIODATA`=17'h10000, `CHANGED`=0, `STABLE`=1. Set `PARITYSEL`=1 → `GPIODATA`=17'h00000 in the same cycle.
2. **Steady change:** `PADIN` 16'h0000→16'h00A5, held, `PARITYSEL`=0 → `GPIODATA`=17'h100A5 exactly at edge 7, `CHANGED`=1 for that one cycle only, `STABLE` low from edge 2 until edge 6.
3. **Glitch rejection:** `PADIN[0]` high for 3 cycles, then low → `GPIODATA` stays 17'h10000, `CHANGED` never asserts, `STABLE` returns to 1.
4. **Parity mode switch:** with `GPIODATA[15:0]`=16'h00A5, toggle `PARITYSEL` 0→1 → bit 16 goes 1→0 in the same cycle, `CHANGED`=0, data unchanged.
5. **Staggered bits:** raise `PADIN[3]`, then `PADIN[7]` two cycles later → `GPIODATA[15:0]` becomes 16'h0008 at edge 7 and 16'h0088 at edge 9, with two separate one-cycle `CHANGED` pulses.
6. **Reset mid-count:** `PADIN`=16'h00A5, assert `HRESETn` low after 5 cycles → `GPIODATA[15:0]`=0 immediately. After release with the pad held, data 16'h00A5 appears at the 7th post-reset edge.
